imem_fetch_ctrl: RTL
====================

# imem_fetch_ctrl

Instruction fetch controller that sequences the `Instruction_Memory` block. It owns the program counter and drives the memory read address. Each returned instruction word is buffered with its PC in a small FIFO and handed to decode over a valid/ready handshake. It also handles branch/jump redirects, halt requests and misaligned-target detection, and sits between `Instruction_Memory` and the decode stage of the core.

## Interface
Parameters:
- `ADDR_W`, 32, PC / memory address width
- `DATA_W`, 32, instruction word width
- `RESET_PC`, 32'h0000_0000, PC loaded on reset; must be 4-byte aligned
- `DEPTH`, 2, fetch FIFO entries; power of two, at least 2

Ports:
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  synchronous, active-high reset
- `imem_addr`  out  ADDR_W  read address to `Instruction_Memory` (`read_address`)
- `imem_data`  in  DATA_W  instruction word from memory (`instruction_out`); combinational, valid in the same cycle as `imem_addr`
- `redirect`  in  1  branch/jump taken; single-cycle pulse
- `redirect_pc`  in  ADDR_W  target address, sampled when `redirect`=1
- `halt_req`  in  1  level; stop issuing new fetches
- `out_valid`  out  1  FIFO head holds a valid instruction
- `out_ready`  in  1  decode accepts the head this cycle
- `out_instr`  out  DATA_W  head instruction word
- `out_pc`  out  ADDR_W  PC of the head instruction
- `halted`  out  1  controller is in HALT
- `misalign_err`  out  1  sticky; set by a misaligned redirect target

## Operation
- FSM states:
  - RESET: the state for the single cycle after `rst` falls; no fetch is issued.
  - FETCH: normal fetching.
  - HALT: no fetches are issued; the FIFO still drains.
- FSM transitions:
  - RESET -> FETCH unconditionally.
  - FETCH -> HALT when `halt_req`=1, or on a misaligned redirect.
  - HALT -> FETCH on an aligned redirect with `halt_req`=0.
  - HALT with `halt_req`=1 and an aligned redirect: `pc` is updated and the FIFO is flushed; the FSM stays in HALT.
- `imem_addr` = `pc` at all times.
- Fetch fires in a cycle when: state=FETCH, `halt_req`=0, `redirect`=0, and (count < DEPTH, or a pop occurs in the same cycle).
  - On fire: push {`pc`, `imem_data`} into the FIFO and set `pc` <= `pc` + 4.
  - The PC increment wraps modulo 2^ADDR_W, with no error.
- Pop: `out_valid` && `out_ready` && !`redirect`.
- `out_valid` = (count != 0); it depends only on registered state.
- Redirect has priority over fetch, pop and halt.
  - The FIFO is flushed (count <= 0), and no push or pop happens that cycle.
  - A handshake that appears in a redirect cycle is void; decode squashes it.
- Aligned redirect (`redirect_pc[1:0]`=0): `pc` <= `redirect_pc`.
- Misaligned redirect:
  - `pc` is unchanged and the FIFO is flushed.
  - `misalign_err` <= 1 and stays set until `rst`.
  - The state goes to HALT.
- While `misalign_err`=1, only `rst` leaves HALT; further redirects update `pc` only.
- Simultaneous push and pop on a full FIFO is legal; count is unchanged.
- `halt_req` deasserted while in HALT without a redirect: the FSM stays in HALT and resumes only via redirect.

## Timing
- Reset values:
  - `pc`=`RESET_PC`, `imem_addr`=`RESET_PC`, count=0
  - `out_valid`=0, `out_instr`=0, `out_pc`=0
  - `halted`=0, `misalign_err`=0, state=RESET
- Reset mid-operation discards the FIFO contents and any pending redirect.
- Memory read latency is 0 cycles; the instruction is captured at the edge ending the fetch cycle.
- Fetch-to-`out_valid` latency is 1 cycle. The first `out_valid` appears 2 cycles after `rst` falls.
- Redirect-to-first-valid-target-instruction latency is 2 cycles: redirect cycle, fetch of target, then valid.
- Sustained throughput is 1 instruction per cycle while `out_ready`=1.
- With `out_ready`=0, fetch stops after DEPTH pushes; `pc` holds at the next unfetched address.
- `halted` and `misalign_err` update one edge after the causing event.

## Structure
- Package `fetch_pkg`:
  - FSM state enum `fetch_state_t` {RESET, FETCH, HALT}
  - constant `PC_STEP`=4
  - alignment-check function `is_aligned(addr)`
- Sub-module `fetch_fifo`:
  - Synchronous, parameterised DEPTH × (ADDR_W+DATA_W).
  - Ports: push, pop, flush, full, empty, count.
  - flush has priority over push and pop.
- The top level holds the FSM, `pc` and the redirect logic; the memory itself stays outside the block.

## Test plan
- Reset release, memory preloaded, `out_ready`=1 -> heads appear in order with `out_pc` = 0, 4, 8, 12…, matching memory words, 1 per cycle from cycle 2.
- Hold `out_ready`=0 for 5 cycles -> exactly 2 entries buffered, `imem_addr` frozen at 8. Release -> PCs 0, 4, 8 are delivered in order with no gap or duplicate.
- `redirect`=1, `redirect_pc`=40 while the FIFO is full -> FIFO flushed; next heads have `out_pc` = 40, 44, 48 two cycles later; the handshake in the redirect cycle is void.
- `redirect_pc`=94 -> `misalign_err`=1 and `halted`=1 next cycle, `pc` unchanged, no further `out_valid`. Then `redirect_pc`=100 -> still halted; only `rst` clears it.
- `halt_req`=1 mid-stream -> fetch stops, buffered entries drain, `halted`=1. A redirect to 72 with `halt_req`=0 -> resumes with `out_pc` = 72, 76.
- `RESET_PC`=32'hFFFF_FFF8 -> `out_pc` sequence F8, FC, 0, 4 (wrap), with no error flagged.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and helpers for the instruction fetch controller.
package fetch_pkg;

  typedef enum logic [1:0] {
    RESET = 2'd0,
    FETCH = 2'd1,
    HALT  = 2'd2
  } fetch_state_t;

  localparam int PC_STEP = 4;

  function automatic logic is_aligned(input logic [1:0] addr);
    return (addr == 2'b00);
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO pairing each fetched instruction word with its PC.
module fetch_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  // A push into a full FIFO is only accepted when the head leaves in the same cycle.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

endmodule

// File: rtl/imem_fetch_ctrl.sv
// Fetch sequencer: owns the PC, feeds Instruction_Memory and buffers words for decode.
//   state | meaning
//   RESET | first cycle after reset release, no fetch
//   FETCH | issuing one fetch per cycle while the FIFO has room
//   HALT  | no fetches; FIFO drains; left only via aligned redirect (or rst after an error)
module imem_fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int               ADDR_W   = 32,
  parameter int               DATA_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int               DEPTH    = 2
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [DATA_W-1:0] imem_data,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  input  logic              halt_req,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_instr,
  output logic [ADDR_W-1:0] out_pc,
  output logic              halted,
  output logic              misalign_err
);

  fetch_state_t              state;
  logic [ADDR_W-1:0]         pc;
  logic [ADDR_W+DATA_W-1:0]  fifo_dout;
  logic                      fifo_full;
  logic                      fifo_empty;
  logic [$clog2(DEPTH):0]    fifo_count;
  logic                      pop;
  logic                      fire;
  logic                      aligned;

  assign imem_addr = pc;
  assign out_valid = (fifo_count != '0);
  assign out_pc    = fifo_dout[DATA_W +: ADDR_W];
  assign out_instr = fifo_dout[DATA_W-1:0];
  assign aligned   = is_aligned(redirect_pc[1:0]);

  // A handshake coinciding with a redirect is squashed by decode, so it never pops.
  assign pop  = !fifo_empty && out_ready && !redirect;
  assign fire = (state == FETCH) && !halt_req && !redirect && (!fifo_full || pop);

  fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ADDR_W + DATA_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fire),
    .pop   (pop),
    .flush (redirect),
    .din   ({pc, imem_data}),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= RESET;
      pc           <= RESET_PC;
      halted       <= 1'b0;
      misalign_err <= 1'b0;
    end else if (redirect) begin
      if (aligned) begin
        pc <= redirect_pc;
        // An error latch pins the controller in HALT until reset.
        if (state == HALT && (halt_req || misalign_err)) begin
          state  <= HALT;
          halted <= 1'b1;
        end else begin
          state  <= FETCH;
          halted <= 1'b0;
        end
      end else begin
        misalign_err <= 1'b1;
        state        <= HALT;
        halted       <= 1'b1;
      end
    end else begin
      unique case (state)
        RESET: begin
          state  <= FETCH;
          halted <= 1'b0;
        end
        FETCH: begin
          if (halt_req) begin
            state  <= HALT;
            halted <= 1'b1;
          end else if (fire) begin
            pc <= pc + ADDR_W'(PC_STEP);
          end
        end
        HALT: begin
          state  <= HALT;
          halted <= 1'b1;
        end
        default: begin
          state  <= HALT;
          halted <= 1'b1;
        end
      endcase
    end
  end

endmodule
